deserializer: RTL and testbench
===============================

DESERIALIZER -- requirements
Module: deserializer

Interface
REQ-001 The block SHALL expose parameter DATA_W, default 8, giving the number of data bits per frame (legal 1..16).
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port enable, input, 1 bit: receive enable; low aborts any frame in progress.
REQ-005 The block SHALL have port sIn, input, 1 bit: serial data line.
REQ-006 The block SHALL have port sValid, input, 1 bit: bit strobe; sIn is sampled only in cycles where sValid=1.
REQ-007 The block SHALL have port dataOut, output, DATA_W bits: last correctly received word.
REQ-008 The block SHALL have port desDone, output, 1 bit: one-cycle pulse marking a new valid dataOut; drives the address counter increment.
REQ-009 The block SHALL have port frameErr, output, 1 bit: one-cycle pulse marking a bad stop bit.
REQ-010 The block SHALL have port busy, output, 1 bit: high while a frame is in progress (state not IDLE).

Function
REQ-011 Frame format SHALL be: start bit 0, then DATA_W data bits LSB first, then stop bit 1, one bit per sValid strobe.
REQ-012 The FSM SHALL have states IDLE, DATA and STOP.
REQ-013 IDLE: sValid=1 with sIn=0 and enable=1 -> DATA with bit counter cleared; sValid=1 with sIn=1 is ignored (line idle).
REQ-014 DATA: each strobe shifts sIn into bit position bitCnt of a shift register and increments bitCnt; the strobe that carries bit DATA_W-1 moves the FSM to STOP.
REQ-015 STOP: a strobe with sIn=1 loads dataOut from the shift register, pulses desDone in the next cycle, and moves the FSM to IDLE.
REQ-016 STOP: a strobe with sIn=0 pulses frameErr in the next cycle, leaves dataOut unchanged, and moves the FSM to IDLE.
REQ-017 Latency SHALL be one clock from the stop-bit strobe edge to desDone/frameErr high, and each pulse SHALL last exactly one cycle.
REQ-018 desDone and frameErr SHALL never be high in the same cycle.
REQ-019 Cycles with sValid=0 SHALL hold all state, including back-to-back strobes on consecutive cycles and arbitrary gaps between strobes.
REQ-020 enable=0 SHALL force IDLE on the next edge and discard the partial word; dataOut SHALL hold and no pulse SHALL be generated.
REQ-021 A start bit SHALL be accepted on the strobe immediately following a stop bit, with no idle bit required.
REQ-022 bitCnt SHALL be $clog2(DATA_W+1) bits wide and SHALL never exceed DATA_W-1 while in DATA.

Reset
REQ-023 reset low SHALL immediately force state IDLE, bitCnt 0, shift register 0, dataOut 0, desDone 0, frameErr 0 and busy 0, regardless of clock.
REQ-024 Reset asserted mid-frame SHALL discard the frame; after reset release the first valid start bit SHALL begin a new frame.

Structure
REQ-025 The state enum (IDLE, DATA, STOP) and the default DATA_W constant SHALL reside in a shared package, serial_pkg, also used by the serializer.
REQ-026 The block SHALL be a single module with no sub-modules; the bit counter SHALL be inline.

Verification
REQ-027 The bench SHALL cover a frame of 0,1,0,1,0,0,1,0,1,1 with DATA_W=8 -> dataOut=0x4A and one desDone pulse one cycle after the stop strobe.
REQ-028 The bench SHALL cover the same data with stop bit 0 -> one frameErr pulse, no desDone, and dataOut unchanged from its prior value.
REQ-029 The bench SHALL cover two frames (0xFF then 0x00) with consecutive-cycle strobes and no idle bit between them -> two desDone pulses and the final dataOut=0x00.
REQ-030 The bench SHALL cover random sValid gaps of 0-5 cycles within a 0xC3 frame -> dataOut=0xC3.
REQ-031 The bench SHALL cover enable dropped after 4 data bits, then a full frame of 0x5A -> no pulse for the aborted frame and dataOut=0x5A afterwards.
REQ-032 The bench SHALL cover reset asserted between clock edges mid-frame -> all outputs 0 at once, and the next frame received correctly.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial link blocks (serializer and deserializer).
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } ser_state_e;

  localparam int DEFAULT_DATA_W = 8;

  // Bit counter width: wide enough to hold the value DATA_W itself.
  function automatic int cnt_width(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/deserializer_if.sv
// Serial receive side plus parallel word/status outputs of the deserializer.
interface deserializer_if #(
  parameter int DATA_W = serial_pkg::DEFAULT_DATA_W
);

  logic              enable;
  logic              sIn;
  logic              sValid;
  logic [DATA_W-1:0] dataOut;
  logic              desDone;
  logic              frameErr;
  logic              busy;

  // master: the line driver / consumer; slave: the deserializer itself
  modport master (
    output enable, sIn, sValid,
    input  dataOut, desDone, frameErr, busy
  );

  modport slave (
    input  enable, sIn, sValid,
    output dataOut, desDone, frameErr, busy
  );

endinterface

// File: rtl/deserializer.sv
// Receives start(0) + DATA_W data bits LSB first + stop(1), one bit per sValid strobe,
// and presents the word with a one-cycle desDone pulse (or frameErr on a bad stop bit).
module deserializer
  import serial_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input logic           clock,
  input logic           reset,
  deserializer_if.slave bus
);

  localparam int CNT_W = cnt_width(DATA_W);

  ser_state_e        state_q,   state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q,   shift_d;
  logic [DATA_W-1:0] data_q,    data_d;
  logic              done_q,    done_d;
  logic              err_q,     err_d;
  logic [DATA_W-1:0] bit_mask;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    bit_mask  = DATA_W'(1) << bit_cnt_q;

    if (!bus.enable) begin
      // Abort: drop the partial word silently, keep the last good dataOut.
      state_d   = IDLE;
      bit_cnt_d = '0;
    end else if (bus.sValid) begin
      unique case (state_q)
        IDLE: begin
          if (!bus.sIn) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          shift_d = bus.sIn ? (shift_q | bit_mask) : (shift_q & ~bit_mask);
          if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
            state_d   = STOP;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
        STOP: begin
          state_d = IDLE;
          if (bus.sIn) begin
            data_d = shift_q;
            done_d = 1'b1;
          end else begin
            err_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.dataOut  = data_q;
  assign bus.desDone  = done_q;
  assign bus.frameErr = err_q;
  assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_deserializer.sv
// Self-checking bench: directed vector table, hand-written corner sequences and a
// randomized frame-level run against a word/pulse-count reference model.
module tb_deserializer;

  localparam int W = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  deserializer_if #(.DATA_W(W)) bus ();

  deserializer #(.DATA_W(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int   n_checks  = 0;
  int   n_pass    = 0;
  int   done_cnt  = 0;
  int   err_cnt   = 0;
  logic prev_done = 1'b0;
  logic prev_err  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Pulses: never both at once, never two cycles in a row; also counted for the model.
  always @(negedge clock) begin
    if (reset) begin
      check("pulse_rules", 32'({bus.desDone & bus.frameErr,
                                bus.desDone & prev_done,
                                bus.frameErr & prev_err}), 32'd0);
      if (bus.desDone)  done_cnt++;
      if (bus.frameErr) err_cnt++;
      prev_done = bus.desDone;
      prev_err  = bus.frameErr;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // One strobe; returns at the negedge after the sampling edge, where pulses are visible.
  task automatic strobe(input logic b);
    bus.sValid = 1'b1;
    bus.sIn    = b;
    @(negedge clock);
    bus.sValid = 1'b0;
    bus.sIn    = 1'b1;
  endtask

  task automatic send_frame(input logic [W-1:0] d, input logic stop, input int max_gap);
    idle(int'($urandom_range(max_gap, 0)));
    strobe(1'b0);
    for (int i = 0; i < W; i++) begin
      idle(int'($urandom_range(max_gap, 0)));
      strobe(d[i]);
    end
    idle(int'($urandom_range(max_gap, 0)));
    strobe(stop);
  endtask

  typedef struct {
    logic [W-1:0] data;
    logic         stop;
    logic [W-1:0] exp_data;
    logic         exp_done;
    logic         exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [9:0]   bits_27;
    int           d0, e0;
    logic [W-1:0] exp_data;
    int           exp_done, exp_err;

    vecs[0] = '{8'h4A, 1'b1, 8'h4A, 1'b1, 1'b0};
    vecs[1] = '{8'h4A, 1'b0, 8'h4A, 1'b0, 1'b1};
    vecs[2] = '{8'h96, 1'b0, 8'h4A, 1'b0, 1'b1};
    vecs[3] = '{8'h01, 1'b1, 8'h01, 1'b1, 1'b0};
    vecs[4] = '{8'h80, 1'b1, 8'h80, 1'b1, 1'b0};
    vecs[5] = '{8'h00, 1'b0, 8'h80, 1'b0, 1'b1};

    bus.enable = 1'b1;
    bus.sValid = 1'b0;
    bus.sIn    = 1'b1;

    // Reset state
    repeat (2) @(negedge clock);
    check("rst_dataOut",  32'(bus.dataOut),  32'd0);
    check("rst_desDone",  32'(bus.desDone),  32'd0);
    check("rst_frameErr", 32'(bus.frameErr), 32'd0);
    check("rst_busy",     32'(bus.busy),     32'd0);
    reset = 1'b1;
    idle(2);

    // Start bit, then data 0,1,0,1,0,0,1,0 (LSB first = 0x4A), stop 1, then an idle 1.
    bits_27 = 10'b11_0100_1010;
    strobe(1'b0);
    check("f27_busy", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 8; i++) strobe(bits_27[i]);
    check("f27_no_early_done", 32'(bus.desDone), 32'd0);
    strobe(bits_27[8]);
    check("f27_done",    32'(bus.desDone), 32'd1);
    check("f27_dataOut", 32'(bus.dataOut), 32'h4A);
    strobe(bits_27[9]);
    check("f27_done_off", 32'(bus.desDone), 32'd0);
    check("f27_idle",     32'(bus.busy),    32'd0);

    // Vector table
    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].data, vecs[i].stop, 2);
      check($sformatf("vec%0d_dataOut", i),  32'(bus.dataOut),  32'(vecs[i].exp_data));
      check($sformatf("vec%0d_desDone", i),  32'(bus.desDone),  32'(vecs[i].exp_done));
      check($sformatf("vec%0d_frameErr", i), 32'(bus.frameErr), 32'(vecs[i].exp_err));
      idle(1);
      check($sformatf("vec%0d_pulse_end", i), 32'({bus.desDone, bus.frameErr}), 32'd0);
    end

    // Back-to-back frames, no idle bit between stop and next start
    #1 d0 = done_cnt;
    send_frame(8'hFF, 1'b1, 0);
    check("b2b_first",  32'(bus.dataOut), 32'hFF);
    send_frame(8'h00, 1'b1, 0);
    check("b2b_done",   32'(bus.desDone), 32'd1);
    check("b2b_second", 32'(bus.dataOut), 32'h00);
    #1 check("b2b_pulses", 32'(done_cnt - d0), 32'd2);

    // Random gaps of 0-5 cycles between strobes
    send_frame(8'hC3, 1'b1, 5);
    check("gap_done",    32'(bus.desDone), 32'd1);
    check("gap_dataOut", 32'(bus.dataOut), 32'hC3);

    // Enable dropped after 4 data bits, then a full frame
    #1 begin d0 = done_cnt; e0 = err_cnt; end
    strobe(1'b0);
    for (int i = 0; i < 4; i++) strobe(1'b1);
    bus.enable = 1'b0;
    bus.sValid = 1'b1;
    bus.sIn    = 1'b1;
    @(negedge clock);
    bus.sValid = 1'b0;
    check("abort_idle", 32'(bus.busy),    32'd0);
    check("abort_hold", 32'(bus.dataOut), 32'hC3);
    bus.enable = 1'b1;
    idle(1);
    send_frame(8'h5A, 1'b1, 1);
    check("abort_dataOut", 32'(bus.dataOut), 32'h5A);
    #1 check("abort_pulses", 32'({done_cnt - d0, err_cnt - e0}), {32'd1, 32'd0});

    // Reset between clock edges mid-frame
    strobe(1'b0);
    strobe(1'b1);
    strobe(1'b0);
    check("mid_busy", 32'(bus.busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("async_dataOut", 32'(bus.dataOut), 32'd0);
    check("async_busy",    32'(bus.busy),    32'd0);
    check("async_pulses",  32'({bus.desDone, bus.frameErr}), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    idle(1);
    send_frame(8'h3C, 1'b1, 1);
    check("post_rst_done",    32'(bus.desDone), 32'd1);
    check("post_rst_dataOut", 32'(bus.dataOut), 32'h3C);

    // Randomized frames against a frame-level model: a good stop updates the word and
    // adds a desDone, a bad stop adds a frameErr, an abort changes nothing.
    #1;
    exp_data = 8'h3C;
    exp_done = done_cnt;
    exp_err  = err_cnt;
    for (int n = 0; n < 40; n++) begin
      int           kind;
      logic [W-1:0] d;
      d    = W'($urandom);
      kind = int'($urandom_range(9, 0));
      repeat ($urandom_range(2, 0)) begin
        idle(int'($urandom_range(2, 0)));
        strobe(1'b1);
      end
      if (kind == 0) begin
        int k;
        k = int'($urandom_range(W, 0));
        strobe(1'b0);
        for (int i = 0; i < k; i++) strobe(d[i]);
        bus.enable = 1'b0;
        bus.sValid = 1'($urandom);
        bus.sIn    = 1'($urandom);
        @(negedge clock);
        bus.sValid = 1'b0;
        bus.sIn    = 1'b1;
        bus.enable = 1'b1;
      end else begin
        logic stop;
        stop = (kind > 2);
        send_frame(d, stop, 3);
        if (stop) begin
          exp_data = d;
          exp_done++;
        end else begin
          exp_err++;
        end
      end
      idle(1);
      #1;
      check($sformatf("rnd%0d_dataOut", n),  32'(bus.dataOut), 32'(exp_data));
      check($sformatf("rnd%0d_done_cnt", n), 32'(done_cnt),    32'(exp_done));
      check($sformatf("rnd%0d_err_cnt", n),  32'(err_cnt),     32'(exp_err));
    end

    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
